key_debounce16: RTL
===================

# key_debounce16

Sixteen-key debouncer and latch that sits directly upstream of the two-stage 16-to-4 priority encoder and BCD 7-segment display path. It synchronises 16 raw active-low key lines and filters contact bounce with a shared sample tick. It drives clean active-low key lines plus the encoder cascade enable. An optional hold mode keeps the last pressed key asserted, so the display persists after release.

## Interface
- `TICK_DIV`, default 50000: clock cycles per debounce sample tick (1 ms at 50 MHz); must be ≥2.
- `STABLE_N`, default 4: consecutive equal samples required to change a key's debounced state; must be 2..8.

- `CLK`  in  1  system clock; all logic on rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `KeyRaw`  in  16  raw key lines, active-low (0 = pressed), asynchronous to `CLK`.
- `Enable`  in  1  synchronous; 1 = keypad active.
- `Latch`  in  1  synchronous; 1 = hold mode, 0 = live mode.
- `Clear`  in  1  synchronous pulse; clears the held key.
- `KeyOut`  out  16  debounced or held keys, active-low. `[15:8]` feeds the high-priority encoder byte and `[7:0]` feeds the low byte.
- `EI`  out  1  active-low enable for the high-priority encoder.
- `KeyValid`  out  1  1 while any debounced key is pressed.
- `KeyPress`  out  1  one-cycle pulse on any debounced press.
- `KeyCode`  out  4  index of the highest newly pressed key.

## Operation
- Synchroniser:
  - Two flops per bit; reset value 1.
  - `KeyRaw` is seen 2 cycles late.
- Tick generator:
  - Counter runs 0..`TICK_DIV`-1 and wraps.
  - `tick`=1 when count = `TICK_DIV`-1.
  - Counter resets to 0 and always runs, regardless of `Enable`.
- Per-key filter:
  - A `STABLE_N`-bit shift register per key, reset to all 1s, shifts in the synchronised bit on `tick`.
  - Debounced state `Deb[i]` is reset to 1.
  - If the post-shift register is all 0s and `Deb[i]`=1, set `Deb[i]` to 0. This is a press event for key i.
  - If the post-shift register is all 1s and `Deb[i]`=0, set `Deb[i]` to 1. This is a release.
  - Any mixed pattern holds `Deb[i]`.
- Press handling, evaluated on the same edge as the `Deb` update:
  - Let P be the set of keys with a press event on this tick.
  - If P is non-empty: `KeyPress`=1 for exactly one cycle, and `KeyCode` = highest index in P.
  - `KeyCode` otherwise holds its value.
- Hold register `Hold[15:0]`:
  - Reset value `16'hFFFF`.
  - On a press event, `Hold` = all 1s except 0 at the highest index in P.
  - Else, if `Clear`=1, `Hold` = `16'hFFFF`.
  - Press wins over simultaneous `Clear`.
  - `Hold` updates in both modes.
- Outputs (all registered):
  - `KeyOut` = `Latch` ? `Hold` : `Deb`, forced to `16'hFFFF` when `Enable`=0.
  - `EI` = ~`Enable`.
  - `KeyValid` = (`Deb` != `16'hFFFF`) & `Enable`.
  - While `Enable`=0, filters keep running, but `KeyPress` is suppressed and `Hold`/`KeyCode` do not update.

## Timing
- Reset values: `KeyOut`=`16'hFFFF`, `EI`=1, `KeyValid`=0, `KeyPress`=0, `KeyCode`=0. Counter, synchronisers, shift registers, `Deb` and `Hold` take the reset values listed above.
- Reset asserted mid-operation returns every register to its reset value immediately. Filtering restarts from scratch after release.
- Press/release latency from a clean `KeyRaw` edge to `Deb`:
  - Minimum 2+(`STABLE_N`-1)·`TICK_DIV`+1 cycles.
  - Maximum 2+`STABLE_N`·`TICK_DIV` cycles.
- `KeyOut`, `KeyValid`, `KeyPress` and `KeyCode` all change on the edge after `Deb` changes: one register stage after the filter.
- `Latch`, `Enable` and `Clear` affect the outputs on the next edge (1-cycle latency).
- A bounce shorter than `STABLE_N` ticks never changes `Deb`.
- Tick counter wrap: `TICK_DIV`-1 → 0 with no skipped or duplicated tick.

## Test plan
All scenarios use `TICK_DIV`=4 and `STABLE_N`=3, with `Enable`=1 unless stated.
- **Clean press, live mode.** `Latch`=0; drive `KeyRaw`=`16'hFFDF` (key 5) cleanly.
  - Within 14 cycles plus one output stage: `KeyOut`=`16'hFFDF`, `KeyValid`=1, one `KeyPress` pulse, `KeyCode`=5.
  - Release: `KeyOut`=`16'hFFFF` and `KeyValid`=0 within the same bound, with no `KeyPress`.
- **Bounce rejection.** Toggle `KeyRaw[9]` every 5 cycles for 60 cycles, then hold it at 0.
  - No change and no `KeyPress` while bouncing.
  - Exactly one `KeyPress` with `KeyCode`=9 after the line settles.
- **Simultaneous press.** Keys 3 and 12 go low in the same cycle, in hold mode.
  - One `KeyPress`, `KeyCode`=12, `Hold`/`KeyOut`=`16'hEFFF`.
  - After both keys release, `KeyOut` stays `16'hEFFF`.
- **Clear versus press.** Assert `Clear` on the exact cycle a key-0 press event fires.
  - `KeyOut`=`16'hFFFE` (press wins).
  - A later `Clear` alone gives `KeyOut`=`16'hFFFF` on the next edge.
- **Enable gating.** Drop `Enable` while key 7 is held.
  - Next edge: `KeyOut`=`16'hFFFF`, `EI`=1, `KeyValid`=0.
  - A key-2 press while disabled produces no `KeyPress`.
  - Re-enable with key 2 still held: `KeyOut` (live mode) shows `16'hFF7B`.
- **Reset mid-press.** Pulse `RST_N` low for 1 cycle partway through debouncing.
  - All outputs return to reset values asynchronously.
  - The press is re-debounced with full latency after reset release.

Source files
------------

// File: rtl/key_debounce16.sv
// Sixteen-key debouncer/latch feeding the cascaded 16-to-4 priority encoder.
// Raw active-low keys are synchronised, filtered on a shared tick, then registered out.
module key_debounce16 #(
   parameter int TICK_DIV = 50000,
   parameter int STABLE_N = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [15:0] KeyRaw,
   input  logic        Enable,
   input  logic        Latch,
   input  logic        Clear,
   output logic [15:0] KeyOut,
   output logic        EI,
   output logic        KeyValid,
   output logic        KeyPress,
   output logic [3:0]  KeyCode
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [15:0]   sync1_q;
   logic [15:0]   sync2_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          tick;

   logic [15:0]   deb_q;
   logic [15:0]   deb_d;
   logic [15:0]   press_evt;
   logic [15:0]   press_q;

   logic [15:0]   hold_q;
   logic [15:0]   hold_d;
   logic [3:0]    code_q;
   logic [3:0]    code_d;
   logic          kp_q;
   logic          kp_d;
   logic [15:0]   key_out_q;
   logic [15:0]   key_out_d;
   logic          ei_q;
   logic          ei_d;
   logic          valid_q;
   logic          valid_d;
   logic [3:0]    top_idx;

   // Free-running sample tick, independent of Enable.
   assign tick  = (cnt_q == CW'(TICK_DIV - 1));
   assign cnt_d = tick ? '0 : cnt_q + 1'b1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= '1;
         sync2_q <= '1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= KeyRaw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_key
         logic [STABLE_N-1:0] shift_q;
         logic [STABLE_N-1:0] shift_nx;
         logic                rel_evt;

         assign shift_nx      = {shift_q[STABLE_N-2:0], sync2_q[gi]};
         assign press_evt[gi] = tick & (shift_nx == '0) & deb_q[gi];
         assign rel_evt       = tick & (&shift_nx) & ~deb_q[gi];
         assign deb_d[gi]     = press_evt[gi] ? 1'b0 : (rel_evt ? 1'b1 : deb_q[gi]);

         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               shift_q <= '1;
            end else if (tick) begin
               shift_q <= shift_nx;
            end
         end
      end
   endgenerate

   // press_q carries this tick's press set into the output stage one edge later.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         deb_q   <= '1;
         press_q <= '0;
      end else begin
         deb_q   <= deb_d;
         press_q <= press_evt;
      end
   end

   always_comb begin
      top_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (press_q[i]) begin
            top_idx = 4'(i);
         end
      end
   end

   // A press beats a coincident Clear; nothing latches while the keypad is disabled.
   always_comb begin
      hold_d = hold_q;
      code_d = code_q;
      kp_d   = 1'b0;
      if (Enable) begin
         if (|press_q) begin
            kp_d   = 1'b1;
            code_d = top_idx;
            hold_d = ~(16'h0001 << top_idx);
         end else if (Clear) begin
            hold_d = '1;
         end
      end
      key_out_d = Enable ? (Latch ? hold_d : deb_q) : '1;
      valid_d   = Enable & (deb_q != '1);
      ei_d      = ~Enable;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hold_q    <= '1;
         code_q    <= '0;
         kp_q      <= 1'b0;
         key_out_q <= '1;
         ei_q      <= 1'b1;
         valid_q   <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         code_q    <= code_d;
         kp_q      <= kp_d;
         key_out_q <= key_out_d;
         ei_q      <= ei_d;
         valid_q   <= valid_d;
      end
   end

   assign KeyOut   = key_out_q;
   assign EI       = ei_q;
   assign KeyValid = valid_q;
   assign KeyPress = kp_q;
   assign KeyCode  = code_q;

endmodule
